crc_checker: RTL and testbench

//   Serial CRC-8 receiver/checker: the far end of the serial CRC-8 transmitter.
//   - Recomputes CRC-8 over incoming payload bits, then compares the 8 trailing CRC bits.
//   - Trailing bits arrive LSB first.
//   - Flags pass/fail once per frame; sits at the receive side of the serial link.

---
 rtl/crc_checker_if.sv | 48 ++++
 rtl/crc_checker.sv | 175 +++++++++++++++++
 tb/tb_crc_checker.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/crc_checker_if.sv
// ============================================================================
// Module  : crc_checker_if
// Purpose : Serial receive link between a CRC-8 checker and its driver.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface crc_checker_if #(
  parameter int CNT_WIDTH = 16
) ();

  logic                 ser_in;
  logic                 data_en;
  logic                 crc_en;
  logic                 busy;
  logic                 done;
  logic                 crc_ok;
  logic                 crc_err;
  logic                 frame_err;
  logic [CNT_WIDTH-1:0] bit_count;

  modport master (
    output ser_in,
    output data_en,
    output crc_en,
    input  busy,
    input  done,
    input  crc_ok,
    input  crc_err,
    input  frame_err,
    input  bit_count
  );

  modport slave (
    input  ser_in,
    input  data_en,
    input  crc_en,
    output busy,
    output done,
    output crc_ok,
    output crc_err,
    output frame_err,
    output bit_count
  );

endinterface

`default_nettype wire

// File: rtl/crc_checker.sv
// ============================================================================
// Module  : crc_checker
// Purpose : Serial CRC-8 receiver; recomputes CRC over payload, checks trailer.
// Revision: 1.0
// ============================================================================
`default_nettype none

module crc_checker #(
  parameter int                   CRC_WIDTH = 8,
  parameter logic [CRC_WIDTH-1:0] SEED      = 8'hD8,
  parameter int                   CNT_WIDTH = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  crc_checker_if.slave  bus
);

  localparam int                   C_CCNT_W  = $clog2(CRC_WIDTH);
  localparam logic [C_CCNT_W-1:0]  C_CCNT_LAST = C_CCNT_W'(CRC_WIDTH - 1);
  localparam logic [C_CCNT_W-1:0]  C_CCNT_ONE  = C_CCNT_W'(1);
  localparam logic [CNT_WIDTH-1:0] C_CNT_ONE   = CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DATA  = 2'd1,
    ST_CHECK = 2'd2
  } state_t;

  state_t                r_state,     w_state;
  logic [CRC_WIDTH-1:0]  r_lfsr,      w_lfsr;
  logic                  r_mismatch,  w_mismatch;
  logic [C_CCNT_W-1:0]   r_crc_cnt,   w_crc_cnt;
  logic [CNT_WIDTH-1:0]  r_bit_count, w_bit_count;
  logic                  r_done,      w_done;
  logic                  r_crc_ok,    w_crc_ok;
  logic                  r_crc_err,   w_crc_err;
  logic                  r_frame_err, w_frame_err;

  logic                  w_bit_mis;
  logic [CRC_WIDTH-1:0]  w_lfsr_step;
  logic [CRC_WIDTH-1:0]  w_lfsr_shift;
  logic [CNT_WIDTH-1:0]  w_cnt_inc;

  // Galois step for the fixed width-8 polynomial; taps land on bits 7, 6 and 2.
  function automatic logic [CRC_WIDTH-1:0] lfsr_step(
    input logic [CRC_WIDTH-1:0] cur,
    input logic                 d
  );
    logic                 fb;
    logic [CRC_WIDTH-1:0] nxt;
    fb       = cur[0] ^ d;
    nxt      = cur;
    nxt[7]   = fb;
    nxt[6]   = cur[7] ^ fb;
    nxt[5:3] = cur[6:4];
    nxt[2]   = cur[3] ^ fb;
    nxt[1:0] = cur[2:1];
    return nxt;
  endfunction

  assign w_bit_mis    = bus.ser_in ^ r_lfsr[0];
  assign w_lfsr_step  = lfsr_step(r_lfsr, bus.ser_in);
  assign w_lfsr_shift = {1'b0, r_lfsr[CRC_WIDTH-1:1]};
  assign w_cnt_inc    = (&r_bit_count) ? r_bit_count : r_bit_count + C_CNT_ONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_lfsr      <= SEED;
      r_mismatch  <= 1'b0;
      r_crc_cnt   <= '0;
      r_bit_count <= '0;
      r_done      <= 1'b0;
      r_crc_ok    <= 1'b0;
      r_crc_err   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_lfsr      <= w_lfsr;
      r_mismatch  <= w_mismatch;
      r_crc_cnt   <= w_crc_cnt;
      r_bit_count <= w_bit_count;
      r_done      <= w_done;
      r_crc_ok    <= w_crc_ok;
      r_crc_err   <= w_crc_err;
      r_frame_err <= w_frame_err;
    end
  end

  always_comb begin
    w_state     = r_state;
    w_lfsr      = r_lfsr;
    w_mismatch  = r_mismatch;
    w_crc_cnt   = r_crc_cnt;
    w_bit_count = r_bit_count;
    w_done      = 1'b0;
    w_crc_ok    = r_crc_ok;
    w_crc_err   = r_crc_err;
    w_frame_err = 1'b0;

    if (bus.data_en && bus.crc_en) begin
      w_frame_err = 1'b1;
      w_state     = ST_IDLE;
      w_lfsr      = SEED;
      w_mismatch  = 1'b0;
      w_crc_cnt   = '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (bus.data_en) begin
            w_lfsr      = w_lfsr_step;
            w_bit_count = C_CNT_ONE;
            w_state     = ST_DATA;
          end else if (bus.crc_en) begin
            // Zero-length frame: this bit is already CRC bit 0, checked against SEED.
            w_lfsr     = w_lfsr_shift;
            w_mismatch = w_bit_mis;
            w_crc_cnt  = C_CCNT_ONE;
            w_state    = ST_CHECK;
          end
        end
        ST_DATA: begin
          if (bus.data_en) begin
            w_lfsr      = w_lfsr_step;
            w_bit_count = w_cnt_inc;
          end else if (bus.crc_en) begin
            w_lfsr     = w_lfsr_shift;
            w_mismatch = w_bit_mis;
            w_crc_cnt  = C_CCNT_ONE;
            w_state    = ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (bus.data_en) begin
            w_frame_err = 1'b1;
            w_state     = ST_IDLE;
            w_lfsr      = SEED;
            w_mismatch  = 1'b0;
            w_crc_cnt   = '0;
          end else if (bus.crc_en) begin
            if (r_crc_cnt == C_CCNT_LAST) begin
              w_done     = 1'b1;
              w_crc_ok   = ~(r_mismatch | w_bit_mis);
              w_crc_err  = r_mismatch | w_bit_mis;
              w_lfsr     = SEED;
              w_mismatch = 1'b0;
              w_crc_cnt  = '0;
              w_state    = ST_IDLE;
            end else begin
              w_lfsr     = w_lfsr_shift;
              w_mismatch = r_mismatch | w_bit_mis;
              w_crc_cnt  = r_crc_cnt + C_CCNT_ONE;
            end
          end
        end
        default: begin
          w_state    = ST_IDLE;
          w_lfsr     = SEED;
          w_mismatch = 1'b0;
          w_crc_cnt  = '0;
        end
      endcase
    end
  end

  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.done      = r_done;
  assign bus.crc_ok    = r_crc_ok;
  assign bus.crc_err   = r_crc_err;
  assign bus.frame_err = r_frame_err;
  assign bus.bit_count = r_bit_count;

endmodule

`default_nettype wire

// File: tb/tb_crc_checker.sv
// ============================================================================
// Module  : tb_crc_checker
// Purpose : Self-checking bench for crc_checker (16-bit and 4-bit counters).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_crc_checker;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  crc_checker_if #(.CNT_WIDTH(16)) bus ();
  crc_checker_if #(.CNT_WIDTH(4))  bus4 ();

  assign bus4.ser_in  = bus.ser_in;
  assign bus4.data_en = bus.data_en;
  assign bus4.crc_en  = bus.crc_en;

  crc_checker #(.CRC_WIDTH(8), .SEED(8'hD8), .CNT_WIDTH(16)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  crc_checker #(.CRC_WIDTH(8), .SEED(8'hD8), .CNT_WIDTH(4)) dut4 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus4)
  );

  typedef struct {
    logic ok;
    int   cnt;
  } exp_t;

  typedef struct {
    logic [63:0] pay;
    int          len;
    logic [7:0]  crc;
    logic        ok;
    int          cnt;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];
  exp_t mon_e;
  logic last_ok;
  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Golden model of the payload LFSR, written from the tap description.
  function automatic logic [7:0] model_step(input logic [7:0] cur, input logic d);
    logic [7:0] n;
    logic       fb;
    fb     = cur[0] ^ d;
    n[7]   = fb;
    n[6]   = cur[7] ^ fb;
    n[5:3] = cur[6:4];
    n[2]   = cur[3] ^ fb;
    n[1:0] = cur[2:1];
    return n;
  endfunction

  function automatic logic [7:0] golden_crc(input logic [63:0] pay, input int len);
    logic [7:0] l;
    l = 8'hD8;
    for (int i = 0; i < len; i++) l = model_step(l, pay[i]);
    return l;
  endfunction

  task automatic tick(input logic d, input logic c, input logic s);
    bus.data_en = d;
    bus.crc_en  = c;
    bus.ser_in  = s;
    @(posedge clk);
    #1;
    bus.data_en = 1'b0;
    bus.crc_en  = 1'b0;
    bus.ser_in  = 1'b0;
  endtask

  task automatic send_frame(input logic [63:0] pay, input int len, input logic [7:0] crc,
                            input logic exp_ok, input int exp_cnt, input bit gaps);
    exp_t e;
    e.ok  = exp_ok;
    e.cnt = exp_cnt;
    sb_q.push_back(e);
    for (int i = 0; i < len; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) tick(1'b0, 1'b0, 1'b0);
      tick(1'b1, 1'b0, pay[i]);
    end
    for (int i = 0; i < 8; i++) begin
      if (gaps && i > 0 && $urandom_range(0, 3) == 0) tick(1'b0, 1'b0, 1'b0);
      tick(1'b0, 1'b1, crc[i]);
      if (i == 6) begin
        check("busy_mid_check", bus.busy, 1'b1);
        check("no_early_done", bus.done, 1'b0);
      end
    end
    check("done_pulse", bus.done, 1'b1);
    check("busy_after_done", bus.busy, 1'b0);
    last_ok = exp_ok;
  endtask

  task automatic random_frame(input bit flip, input bit gaps, input int len);
    logic [63:0] pay;
    logic [7:0]  crc;
    pay = {$urandom, $urandom};
    crc = golden_crc(pay, len);
    if (flip) crc = crc ^ (8'h01 << $urandom_range(0, 7));
    send_frame(pay, len, crc, !flip, len, gaps);
  endtask

  task automatic check_abort(input string tag);
    check({tag, "_frame_err"}, bus.frame_err, 1'b1);
    check({tag, "_busy"}, bus.busy, 1'b0);
    check({tag, "_crc_ok_kept"}, bus.crc_ok, last_ok);
    check({tag, "_crc_err_kept"}, bus.crc_err, !last_ok);
    check({tag, "_no_done"}, bus.done, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    check({tag, "_frame_err_pulse"}, bus.frame_err, 1'b0);
  endtask

  // Scoreboard side: every done pops one expected frame result.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.done === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no frame pending at %0t", $time);
      end else begin
        mon_e = sb_q.pop_front();
        check("crc_ok", bus.crc_ok, mon_e.ok);
        check("crc_err", bus.crc_err, !mon_e.ok);
        check("bit_count", bus.bit_count, mon_e.cnt[15:0]);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test expected finish before %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] pay;

    vecs[0] = '{pay: 64'h0, len: 0, crc: 8'hD8, ok: 1'b1, cnt: 0};
    vecs[1] = '{pay: 64'h0, len: 1, crc: 8'h6C, ok: 1'b1, cnt: 1};
    vecs[2] = '{pay: 64'h1, len: 1, crc: 8'h6C, ok: 1'b0, cnt: 1};
    vecs[3] = '{pay: 64'h1, len: 1, crc: 8'hA8, ok: 1'b1, cnt: 1};
    vecs[4] = '{pay: 64'h0, len: 2, crc: 8'h36, ok: 1'b1, cnt: 2};

    rst_n       = 1'b0;
    bus.ser_in  = 1'b0;
    bus.data_en = 1'b0;
    bus.crc_en  = 1'b0;
    last_ok     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_crc_ok", bus.crc_ok, 1'b0);
    check("rst_crc_err", bus.crc_err, 1'b0);
    check("rst_frame_err", bus.frame_err, 1'b0);
    check("rst_bit_count", bus.bit_count, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Hand-computed vectors: zero-length, single-bit and two-bit frames.
    for (int v = 0; v < 5; v++) begin
      send_frame(vecs[v].pay, vecs[v].len, vecs[v].crc, vecs[v].ok, vecs[v].cnt, 1'b0);
      tick(1'b0, 1'b0, 1'b0);
    end

    for (int f = 0; f < 12; f++) begin
      random_frame(f[0], 1'b1, $urandom_range(8, 64));
      if ($urandom_range(0, 1) == 1) tick(1'b0, 1'b0, 1'b0);
    end

    // Abort by data_en during the CRC phase.
    pay = {$urandom, $urandom};
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, pay[i]);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, pay[i]);
    tick(1'b1, 1'b0, 1'b1);
    check_abort("abort_check");
    random_frame(1'b0, 1'b0, 9);
    tick(1'b0, 1'b0, 1'b0);

    // Abort by data_en and crc_en together during payload.
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, pay[i]);
    tick(1'b1, 1'b1, 1'b0);
    check_abort("abort_data");
    random_frame(1'b0, 1'b0, 10);
    tick(1'b0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of the CRC phase.
    for (int i = 0; i < 6; i++) tick(1'b1, 1'b0, pay[i]);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, pay[i]);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", bus.busy, 1'b0);
    check("midrst_done", bus.done, 1'b0);
    check("midrst_crc_ok", bus.crc_ok, 1'b0);
    check("midrst_crc_err", bus.crc_err, 1'b0);
    check("midrst_bit_count", bus.bit_count, 16'd0);
    check("midrst_bit_count4", bus4.bit_count, 4'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n   = 1'b1;
    last_ok = 1'b0;
    @(posedge clk);
    #1;
    repeat (3) tick(1'b0, 1'b0, 1'b0);
    check("midrst_no_done", bus.done, 1'b0);
    send_frame(64'h0, 1, 8'h6C, 1'b1, 1, 1'b0);

    // Back-to-back frames: second frame starts on the done cycle.
    random_frame(1'b0, 1'b0, 13);
    random_frame(1'b1, 1'b0, 11);
    random_frame(1'b0, 1'b0, 20);
    check("sat_bit_count4", bus4.bit_count, 4'hF);
    check("sat_crc_ok4", bus4.crc_ok, 1'b1);
    check("sat_done4", bus4.done, 1'b1);

    repeat (3) tick(1'b0, 1'b0, 1'b0);
    check("scoreboard_drained", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
